// File: rtl/mc_pkg.sv
// ============================================================================
// Package     : mc_pkg
// Description : Shared state, opcode and datapath-select encodings for the
//               multi-cycle MIPS main controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_main_ctrl_if.sv
// ============================================================================
// Interface   : mc_main_ctrl_if
// Description : Controller <-> datapath bundle: opcode/ready in, enables out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mc_main_ctrl_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       bad_op;
    logic [3:0] state;

    modport master (
        input  op, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_src, bad_op, state
    );

    modport slave (
        output op, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_src, bad_op, state
    );
endinterface

`default_nettype wire

// File: rtl/mc_main_ctrl.sv
// ============================================================================
// Module      : mc_main_ctrl
// Description : Multi-cycle MIPS main control FSM with ready-stretched memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_main_ctrl
    import mc_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     rst,
    mc_main_ctrl_if.master bus
);

    state_t r_state;
    state_t w_next;

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (bus.op == OP_LW || bus.op == OP_SW) w_next = S_MEMADR;
                else if (bus.op == OP_RTYPE)            w_next = S_EXEC;
                else if (bus.op == OP_BEQ)              w_next = S_BRANCH;
                else if (bus.op == OP_J)                w_next = S_JUMP;
                else                                    w_next = S_FETCH;
            end
            S_MEMADR: begin
                if (bus.op == OP_LW)      w_next = S_MEMRD;
                else if (bus.op == OP_SW) w_next = S_MEMWR;
                else                      w_next = S_FETCH;
            end
            S_MEMRD:  w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    logic       w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write;
    logic       w_ir_write, w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a;
    logic       w_bad_op;
    logic [1:0] w_alu_src_b, w_alu_op, w_pc_src;

    // Everything, including the debug state view, is held at zero during reset
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_dst       = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = SRCB_RT;
        w_alu_op        = ALUOP_ADD;
        w_pc_src        = PCSRC_ALU;
        w_bad_op        = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    w_mem_read  = 1'b1;
                    w_alu_src_b = SRCB_FOUR;
                    w_ir_write  = bus.mem_ready;
                    w_pc_write  = bus.mem_ready;
                end
                S_DECODE: begin
                    w_alu_src_b = SRCB_IMM_SH;
                    w_bad_op    = !is_supported(bus.op);
                end
                S_MEMADR: begin
                    w_alu_src_a = 1'b1;
                    w_alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    w_mem_read = 1'b1;
                    w_i_or_d   = 1'b1;
                end
                S_MEMWB: begin
                    w_reg_write  = 1'b1;
                    w_mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    w_mem_write = 1'b1;
                    w_i_or_d    = 1'b1;
                end
                S_EXEC: begin
                    w_alu_src_a = 1'b1;
                    w_alu_op    = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    w_reg_write = 1'b1;
                    w_reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    w_alu_src_a     = 1'b1;
                    w_alu_op        = ALUOP_SUB;
                    w_pc_write_cond = 1'b1;
                    w_pc_src        = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    w_pc_write = 1'b1;
                    w_pc_src   = PCSRC_JUMP;
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_write      = w_pc_write;
    assign bus.pc_write_cond = w_pc_write_cond;
    assign bus.i_or_d        = w_i_or_d;
    assign bus.mem_read      = w_mem_read;
    assign bus.mem_write     = w_mem_write;
    assign bus.ir_write      = w_ir_write;
    assign bus.mem_to_reg    = w_mem_to_reg;
    assign bus.reg_dst       = w_reg_dst;
    assign bus.reg_write     = w_reg_write;
    assign bus.alu_src_a     = w_alu_src_a;
    assign bus.alu_src_b     = w_alu_src_b;
    assign bus.alu_op        = w_alu_op;
    assign bus.pc_src        = w_pc_src;
    assign bus.bad_op        = w_bad_op;
    assign bus.state         = rst ? 4'd0 : r_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_main_ctrl.sv
// ============================================================================
// Module      : tb_mc_main_ctrl
// Description : Self-checking bench for mc_main_ctrl: per-cycle model compare
//               plus literal state-sequence pins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_main_ctrl;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       bad_op;
        logic [3:0] state;
    } ov_t;

    localparam logic [5:0] C_RT = 6'h00, C_LW = 6'h23, C_SW = 6'h2B, C_BEQ = 6'h04, C_J = 6'h02;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_main_ctrl_if bus ();

    mc_main_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    checks  = 0;
    int    errors  = 0;
    int    bad_cnt = 0;
    int    hist[$];
    ov_t   exp_v   = '0;
    bit    exp_valid = 1'b0;
    string tag     = "reset";
    ov_t   act;

    assign act = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                  bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                  bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                  bus.pc_src, bus.bad_op, bus.state};

    // Expected outputs for one cycle, straight from the per-state output table
    function automatic ov_t model(input int ph, input bit mr, input logic [5:0] opv);
        ov_t o = '0;
        o.state = 4'(ph);
        case (ph)
            0: begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
            1: begin o.alu_src_b = 2'b11; o.bad_op = !(opv inside {C_RT, C_LW, C_SW, C_BEQ, C_J}); end
            2: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            3: begin o.mem_read = 1; o.i_or_d = 1; end
            4: begin o.reg_write = 1; o.mem_to_reg = 1; end
            5: begin o.mem_write = 1; o.i_or_d = 1; end
            6: begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            7: begin o.reg_write = 1; o.reg_dst = 1; end
            8: begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_src = 2'b01; end
            9: begin o.pc_write = 1; o.pc_src = 2'b10; end
            default: o = '0;
        endcase
        return o;
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            hist.push_back(int'(act.state));
            if (act.bad_op) bad_cnt++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL %s t=%0t actual=%h required=%h", tag, $time, act, exp_v);
            end
        end
    end

    task automatic step(input bit r, input logic [5:0] opv, input bit mr, input ov_t e);
        @(posedge clk);
        #1;
        rst           = r;
        bus.op        = opv;
        bus.mem_ready = mr;
        exp_v         = e;
        exp_valid     = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic pin(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, a, e);
        end
    endtask

    task automatic pin_seq(input string nm, input int e[$]);
        checks++;
        if (hist != e) begin
            errors++;
            $display("FAIL %s actual=%p required=%p", nm, hist, e);
        end
    endtask

    // One full instruction: fetch (with waits), decode, then the op's own phases
    task automatic run(input string nm, input logic [5:0] opv, input int fw, input int mw);
        int ph[$];
        tag = nm;
        hist.delete();
        repeat (fw) step(0, opv, 0, model(0, 0, opv));
        step(0, opv, 1, model(0, 1, opv));
        step(0, opv, 1, model(1, 1, opv));
        case (opv)
            C_LW:    ph = {2, 3, 4};
            C_SW:    ph = {2, 5};
            C_RT:    ph = {6, 7};
            C_BEQ:   ph = {8};
            C_J:     ph = {9};
            default: ph = {};
        endcase
        foreach (ph[i]) begin
            if (ph[i] == 3 || ph[i] == 5)
                repeat (mw) step(0, opv, 0, model(ph[i], 0, opv));
            step(0, opv, 1, model(ph[i], 1, opv));
        end
    endtask

    initial begin
        int e[$];
        bus.op        = C_LW;
        bus.mem_ready = 1'b0;

        repeat (2) step(1, C_LW, 1, '0);

        run("lw", C_LW, 0, 0);
        e = {0, 1, 2, 3, 4};
        pin_seq("lw_seq", e);

        run("rtype", C_RT, 0, 0);
        e = {0, 1, 6, 7};
        pin_seq("rtype_seq", e);

        run("beq", C_BEQ, 0, 0);
        e = {0, 1, 8};
        pin_seq("beq_seq", e);

        run("j", C_J, 0, 0);
        e = {0, 1, 9};
        pin_seq("j_seq", e);

        run("sw_wait", C_SW, 2, 3);
        e = {0, 0, 0, 1, 2, 5, 5, 5, 5};
        pin_seq("sw_wait_seq", e);

        run("lw_wait", C_LW, 1, 2);
        pin("lw_wait_len", hist.size(), 8);

        bad_cnt = 0;
        run("bad_op", 6'h3F, 0, 0);
        e = {0, 1};
        pin_seq("bad_seq", e);
        pin("bad_pulses", bad_cnt, 1);

        run("after_bad", C_RT, 0, 0);
        pin("after_bad_first", hist[0], 0);

        tag = "rst_memwr";
        step(0, C_SW, 1, model(0, 1, C_SW));
        step(0, C_SW, 1, model(1, 1, C_SW));
        step(0, C_SW, 1, model(2, 1, C_SW));
        step(0, C_SW, 0, model(5, 0, C_SW));
        pin("memwr_before_rst", int'(bus.mem_write), 1);
        step(1, C_SW, 1, '0);
        pin("memwr_in_rst", int'(bus.mem_write), 0);
        step(0, C_SW, 0, model(0, 0, C_SW));
        pin("state_after_rst", int'(bus.state), 0);

        run("beq_end", C_BEQ, 0, 0);
        exp_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
